// File: rtl/biquad_serial_if.sv
// Sample-in / result-out handshake bundle for biquad_serial.
// The filter is the slave; the sample producer/consumer is the master.
interface biquad_serial_if #(
  parameter int DATAWIDTH = 16
);
  logic                 x_valid_i;
  logic [DATAWIDTH-1:0] x_i;
  logic                 x_ready_o;
  logic [DATAWIDTH-1:0] y_o;
  logic                 y_valid_o;
  logic                 busy_o;

  modport master (
    output x_valid_i,
    output x_i,
    input  x_ready_o,
    input  y_o,
    input  y_valid_o,
    input  busy_o
  );

  modport slave (
    input  x_valid_i,
    input  x_i,
    output x_ready_o,
    output y_o,
    output y_valid_o,
    output busy_o
  );
endinterface

// File: rtl/biquad_serial.sv
// Serial Direct Form I biquad: one shared multiplier, five MAC steps,
// round/saturate on the DONE step. Q1.(DATAWIDTH-1) samples and coefficients.
module biquad_serial #(
  parameter int DATAWIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic signed [DATAWIDTH-1:0] a11_i,
  input  logic signed [DATAWIDTH-1:0] a12_i,
  input  logic signed [DATAWIDTH-1:0] b10_i,
  input  logic signed [DATAWIDTH-1:0] b11_i,
  input  logic signed [DATAWIDTH-1:0] b12_i,
  biquad_serial_if.slave              bus
);

  localparam int DW = DATAWIDTH;
  localparam int AW = 2 * DW + 3;

  localparam logic signed [AW-1:0] RND =
    {{(AW-DW+1){1'b0}}, 1'b1, {(DW-2){1'b0}}};
  localparam logic signed [AW-1:0] YMAX =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    MAC3,
    MAC4,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0] x_q,  x_d;
  logic signed [DW-1:0] x1_q, x1_d;
  logic signed [DW-1:0] x2_q, x2_d;
  logic signed [DW-1:0] y1_q, y1_d;
  logic signed [DW-1:0] y2_q, y2_d;

  logic signed [DW-1:0] a11_q, a11_d;
  logic signed [DW-1:0] a12_q, a12_d;
  logic signed [DW-1:0] b10_q, b10_d;
  logic signed [DW-1:0] b11_q, b11_d;
  logic signed [DW-1:0] b12_q, b12_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic        [DW-1:0] y_q,   y_d;
  logic                 yv_q,  yv_d;

  logic signed [DW-1:0]   mul_a;
  logic signed [DW-1:0]   mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_x;
  logic signed [AW-1:0]   rnd;
  logic signed [AW-1:0]   shr;
  logic signed [DW-1:0]   y_sat;

  // Single shared multiplier; operands picked by the MAC step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      MAC0: begin mul_a = b10_q; mul_b = x_q;  end
      MAC1: begin mul_a = b11_q; mul_b = x1_q; end
      MAC2: begin mul_a = b12_q; mul_b = x2_q; end
      MAC3: begin mul_a = a11_q; mul_b = y1_q; end
      MAC4: begin mul_a = a12_q; mul_b = y2_q; end
      default: ;
    endcase
  end

  assign prod   = mul_a * mul_b;
  assign prod_x = {{3{prod[2*DW-1]}}, prod};

  assign rnd = acc_q + RND;
  assign shr = rnd >>> (DW - 1);

  always_comb begin
    y_sat = shr[DW-1:0];
    if (shr > YMAX) begin
      y_sat = YMAX[DW-1:0];
    end else if (shr < YMIN) begin
      y_sat = YMIN[DW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    a11_d   = a11_q;
    a12_d   = a12_q;
    b10_d   = b10_q;
    b11_d   = b11_q;
    b12_d   = b12_q;
    acc_d   = acc_q;
    y_d     = y_q;
    yv_d    = 1'b0;
    // Flush wins over everything, including a new sample.
    if (clr_i) begin
      state_d = IDLE;
      x1_d    = '0;
      x2_d    = '0;
      y1_d    = '0;
      y2_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.x_valid_i) begin
            state_d = MAC0;
            x_d     = bus.x_i;
            a11_d   = a11_i;
            a12_d   = a12_i;
            b10_d   = b10_i;
            b11_d   = b11_i;
            b12_d   = b12_i;
            acc_d   = '0;
          end
        end
        MAC0: begin
          acc_d   = acc_q + prod_x;
          state_d = MAC1;
        end
        MAC1: begin
          acc_d   = acc_q + prod_x;
          state_d = MAC2;
        end
        MAC2: begin
          acc_d   = acc_q + prod_x;
          state_d = MAC3;
        end
        MAC3: begin
          acc_d   = acc_q - prod_x;
          state_d = MAC4;
        end
        MAC4: begin
          acc_d   = acc_q - prod_x;
          state_d = DONE;
        end
        DONE: begin
          y_d     = y_sat;
          yv_d    = 1'b1;
          x2_d    = x1_q;
          x1_d    = x_q;
          y2_d    = y1_q;
          y1_d    = y_sat;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      a11_q   <= '0;
      a12_q   <= '0;
      b10_q   <= '0;
      b11_q   <= '0;
      b12_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      a11_q   <= a11_d;
      a12_q   <= a12_d;
      b10_q   <= b10_d;
      b11_q   <= b11_d;
      b12_q   <= b12_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign bus.busy_o    = (state_q != IDLE);
  assign bus.x_ready_o = (state_q == IDLE);
  assign bus.y_o       = y_q;
  assign bus.y_valid_o = yv_q;

endmodule
